// File: rtl/bcd_interval_timer.sv
// Multi-digit BCD interval timer: programmable tick divider feeding a chain of
// decimal digits with ripple carry/borrow, start/pause/load control and terminal-count detection.
module bcd_interval_timer #(
    parameter int NUM_DIGITS = 4,
    parameter int DIV_COUNT  = 50_000_000,
    parameter int DIV_W      = 26
) (
    input  logic                    fastclock,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    pause,
    input  logic                    load,
    input  logic                    count_down,
    input  logic [4*NUM_DIGITS-1:0] load_value,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic                    tick,
    output logic                    running,
    output logic                    done
);

    localparam int VW = 4 * NUM_DIGITS;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV_COUNT - 1);
    localparam logic [VW-1:0] ALL_NINE = {NUM_DIGITS{4'h9}};

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_q;

    logic [VW-1:0] load_clamped;
    logic [VW-1:0] value_up;
    logic [VW-1:0] value_dn;
    logic          all_nine;
    logic          all_zero;
    logic          at_term;
    logic          step_term;
    logic          div_wrap;

    // Per-digit clamp of the preset plus the incremented and decremented
    // versions of the current count, carry/borrow rippling from digit 0 upward.
    always_comb begin : digit_chain
        logic       carry;
        logic       borrow;
        logic [3:0] d;
        logic [3:0] q;
        load_clamped = '0;
        value_up     = '0;
        value_dn     = '0;
        all_nine     = 1'b1;
        all_zero     = 1'b1;
        carry        = 1'b1;
        borrow       = 1'b1;
        d            = '0;
        q            = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            d = load_value[4*i +: 4];
            load_clamped[4*i +: 4] = (d > 4'd9) ? 4'd9 : d;
            q = value[4*i +: 4];
            if (q != 4'd9) all_nine = 1'b0;
            if (q != 4'd0) all_zero = 1'b0;
            if (!carry) begin
                value_up[4*i +: 4] = q;
            end else if (q == 4'd9) begin
                value_up[4*i +: 4] = 4'd0;
            end else begin
                value_up[4*i +: 4] = q + 4'd1;
                carry = 1'b0;
            end
            if (!borrow) begin
                value_dn[4*i +: 4] = q;
            end else if (q == 4'd0) begin
                value_dn[4*i +: 4] = 4'd9;
            end else begin
                value_dn[4*i +: 4] = q - 4'd1;
                borrow = 1'b0;
            end
        end
    end

    assign at_term   = count_down ? all_zero : all_nine;
    assign step_term = count_down ? (value_dn == '0) : (value_up == ALL_NINE);
    assign div_wrap  = (div_q == DIV_LAST);

    // Control priority is load > pause > start; a high pause also masks start.
    always_ff @(posedge fastclock or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            div_q   <= '0;
            value   <= '0;
            tick    <= 1'b0;
            done    <= 1'b0;
            running <= 1'b0;
        end else begin
            tick <= 1'b0;
            done <= 1'b0;
            if (load) begin
                value   <= load_clamped;
                div_q   <= '0;
                state   <= IDLE;
                running <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        if (pause) begin
                            state   <= PAUSE;
                            running <= 1'b0;
                        end else if (div_wrap) begin
                            div_q <= '0;
                            if (at_term) begin
                                // Mode changed onto the terminal value: finish without a step.
                                done    <= 1'b1;
                                state   <= DONE;
                                running <= 1'b0;
                            end else begin
                                value <= count_down ? value_dn : value_up;
                                tick  <= 1'b1;
                                if (step_term) begin
                                    done    <= 1'b1;
                                    state   <= DONE;
                                    running <= 1'b0;
                                end
                            end
                        end else begin
                            div_q <= div_q + DIV_W'(1);
                        end
                    end
                    PAUSE: begin
                        if (!pause && start) begin
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                    default: begin
                        if (!pause && start && !at_term) begin
                            div_q   <= '0;
                            state   <= RUN;
                            running <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_interval_timer.sv
// Bench for bcd_interval_timer: vector table, hand-written corner sequences and
// randomized traffic against an integer-arithmetic model, on DIV_COUNT=4 and DIV_COUNT=1 instances.
module tb_bcd_interval_timer;

    logic       fastclock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       pause = 1'b0;
    logic       load = 1'b0;
    logic       count_down = 1'b0;
    logic [7:0] load_value = 8'h00;

    logic [7:0] value4, value1;
    logic       tick4, running4, done4;
    logic       tick1, running1, done1;

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: count held as a plain decimal integer.
    // st: 0 = IDLE, 1 = RUN, 2 = PAUSE, 3 = DONE
    typedef struct {
        int val;
        int div;
        int st;
        bit tick;
        bit done;
    } mdl_t;

    typedef struct {
        logic       ld, ps, st, cd;
        logic [7:0] lv;
        logic [7:0] ev;
        logic       et, ed, er;
    } vec_t;

    mdl_t m4, m1;
    vec_t tbl[20];
    logic [7:0] exp_q[$];

    bcd_interval_timer #(.NUM_DIGITS(2), .DIV_COUNT(4), .DIV_W(3)) dut (
        .fastclock(fastclock), .reset(reset), .start(start), .pause(pause),
        .load(load), .count_down(count_down), .load_value(load_value),
        .value(value4), .tick(tick4), .running(running4), .done(done4)
    );

    bcd_interval_timer #(.NUM_DIGITS(2), .DIV_COUNT(1), .DIV_W(1)) dut1 (
        .fastclock(fastclock), .reset(reset), .start(start), .pause(pause),
        .load(load), .count_down(count_down), .load_value(load_value),
        .value(value1), .tick(tick1), .running(running1), .done(done1)
    );

    // clock / watchdog
    always #5 fastclock = ~fastclock;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] bcd(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    function automatic int clamp9(input logic [3:0] d);
        return (d > 4'd9) ? 9 : int'(d);
    endfunction

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.val = 0; m.div = 0; m.st = 0; m.tick = 0; m.done = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input bit ld, input bit ps, input bit s,
                                      input bit cd, input logic [7:0] lv, input int divc);
        mdl_t n;
        int   term;
        n = m;
        n.tick = 0;
        n.done = 0;
        term = cd ? 0 : 99;
        if (ld) begin
            n.val = clamp9(lv[7:4]) * 10 + clamp9(lv[3:0]);
            n.div = 0;
            n.st  = 0;
        end else if (m.st == 1) begin
            if (ps) begin
                n.st = 2;
            end else if (m.div == divc - 1) begin
                n.div = 0;
                if (m.val == term) begin
                    n.done = 1;
                    n.st   = 3;
                end else begin
                    n.val  = cd ? m.val - 1 : m.val + 1;
                    n.tick = 1;
                    if (n.val == term) begin
                        n.done = 1;
                        n.st   = 3;
                    end
                end
            end else begin
                n.div = m.div + 1;
            end
        end else if (!ps && s) begin
            if (m.st == 2) begin
                n.st = 1;
            end else if (m.val != term) begin
                n.div = 0;
                n.st  = 1;
            end
        end
        return n;
    endfunction

    function automatic logic [10:0] mdl_vec(input mdl_t m);
        return {bcd(m.val), m.tick, m.done, (m.st == 1)};
    endfunction

    function automatic vec_t mk(input logic ld, input logic ps, input logic st, input logic cd,
                                input logic [7:0] lv, input logic [7:0] ev,
                                input logic et, input logic ed, input logic er);
        vec_t v;
        v.ld = ld; v.ps = ps; v.st = st; v.cd = cd; v.lv = lv;
        v.ev = ev; v.et = et; v.ed = ed; v.er = er;
        return v;
    endfunction

    // scoreboard
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // driver tasks
    task automatic idle_in();
        load  = 1'b0;
        pause = 1'b0;
        start = 1'b0;
    endtask

    task automatic cyc();
        bit         ld, ps, s, cd;
        logic [7:0] lv;
        ld = load; ps = pause; s = start; cd = count_down; lv = load_value;
        @(posedge fastclock);
        #1;
        m4 = mdl_next(m4, ld, ps, s, cd, lv, 4);
        m1 = mdl_next(m1, ld, ps, s, cd, lv, 1);
        chk("model_div4", {value4, tick4, done4, running4}, mdl_vec(m4));
        chk("model_div1", {value1, tick1, done1, running1}, mdl_vec(m1));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        chk("reset_div4", {value4, tick4, done4, running4}, 11'd0);
        chk("reset_div1", {value1, tick1, done1, running1}, 11'd0);
        m4 = mdl_reset();
        m1 = mdl_reset();
        reset = 1'b0;
    endtask

    task automatic load_start(input logic [7:0] lv, input logic cd);
        idle_in();
        count_down = cd;
        load_value = lv;
        load = 1'b1;
        cyc();
        load = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    initial begin
        int ticks, dones;
        m4 = mdl_reset();
        m1 = mdl_reset();
        do_reset();

        // Reset, first step latency, mid-count reset
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("first_running", {value4, running4}, {8'h00, 1'b1});
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("first_no_tick", tick4, 1'b0);
        end
        cyc();
        chk("first_step", {value4, tick4}, {8'h01, 1'b1});
        for (int i = 0; i < 3; i++) cyc();
        cyc();
        chk("second_step", {value4, tick4}, {8'h02, 1'b1});
        cyc();
        cyc();
        do_reset();
        cyc();
        chk("after_reset_quiet", {value4, done4, running4}, {8'h00, 1'b0, 1'b0});

        // Table-driven vectors: carry, terminal count, clamp and priority
        tbl[0]  = mk(1, 0, 0, 0, 8'h09, 8'h09, 0, 0, 0);
        tbl[1]  = mk(0, 0, 1, 0, 8'h00, 8'h09, 0, 0, 1);
        tbl[2]  = mk(0, 0, 0, 0, 8'h00, 8'h09, 0, 0, 1);
        tbl[3]  = mk(0, 0, 0, 0, 8'h00, 8'h09, 0, 0, 1);
        tbl[4]  = mk(0, 0, 0, 0, 8'h00, 8'h09, 0, 0, 1);
        tbl[5]  = mk(0, 0, 0, 0, 8'h00, 8'h10, 1, 0, 1);
        tbl[6]  = mk(1, 0, 0, 0, 8'h98, 8'h98, 0, 0, 0);
        tbl[7]  = mk(0, 0, 1, 0, 8'h00, 8'h98, 0, 0, 1);
        tbl[8]  = mk(0, 0, 0, 0, 8'h00, 8'h98, 0, 0, 1);
        tbl[9]  = mk(0, 0, 0, 0, 8'h00, 8'h98, 0, 0, 1);
        tbl[10] = mk(0, 0, 0, 0, 8'h00, 8'h98, 0, 0, 1);
        tbl[11] = mk(0, 0, 0, 0, 8'h00, 8'h99, 1, 1, 0);
        tbl[12] = mk(0, 0, 1, 0, 8'h00, 8'h99, 0, 0, 0);
        tbl[13] = mk(1, 1, 1, 0, 8'hAF, 8'h99, 0, 0, 0);
        tbl[14] = mk(1, 0, 0, 0, 8'h3C, 8'h39, 0, 0, 0);
        tbl[15] = mk(0, 0, 1, 1, 8'h00, 8'h39, 0, 0, 1);
        tbl[16] = mk(0, 0, 0, 1, 8'h00, 8'h39, 0, 0, 1);
        tbl[17] = mk(0, 0, 0, 1, 8'h00, 8'h39, 0, 0, 1);
        tbl[18] = mk(0, 0, 0, 1, 8'h00, 8'h39, 0, 0, 1);
        tbl[19] = mk(0, 0, 0, 1, 8'h00, 8'h38, 1, 0, 1);
        for (int i = 0; i < 20; i++) begin
            load = tbl[i].ld; pause = tbl[i].ps; start = tbl[i].st;
            count_down = tbl[i].cd; load_value = tbl[i].lv;
            cyc();
            chk($sformatf("table_row%0d", i), {value4, tick4, done4, running4},
                {tbl[i].ev, tbl[i].et, tbl[i].ed, tbl[i].er});
        end

        // Hold at terminal: 20 cycles without tick
        load_start(8'h98, 1'b0);
        for (int i = 0; i < 4; i++) cyc();
        chk("up_terminal", {value4, tick4, done4, running4}, {8'h99, 1'b1, 1'b1, 1'b0});
        ticks = 0;
        for (int i = 0; i < 20; i++) begin
            cyc();
            if (tick4 || value4 != 8'h99) ticks++;
        end
        chk("hold_terminal", ticks, 0);

        // Down count with borrow, single done pulse
        for (int v = 9; v >= 0; v--) exp_q.push_back(bcd(v));
        load_start(8'h10, 1'b1);
        ticks = 0;
        dones = 0;
        for (int i = 0; i < 60; i++) begin
            cyc();
            if (tick4) begin
                ticks++;
                if (exp_q.size() == 0) chk("down_extra_tick", 1, 0);
                else chk("down_value", value4, exp_q.pop_front());
            end
            if (done4) begin
                dones++;
                chk("down_done_value", value4, 8'h00);
            end
        end
        chk("down_ticks", ticks, 10);
        chk("down_dones", dones, 1);
        chk("down_final", {value4, running4}, {8'h00, 1'b0});
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("start_at_terminal", running4, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("stay_stopped", {running4, done4}, 2'b00);
        end

        // Pause keeps divider residue
        load_start(8'h00, 1'b0);
        cyc();
        cyc();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("paused", {value4, tick4, running4}, {8'h00, 1'b0, 1'b0});
        end
        pause = 1'b0;
        start = 1'b1;
        cyc();
        start = 1'b0;
        chk("resume_running", running4, 1'b1);
        cyc();
        chk("resume_no_tick", tick4, 1'b0);
        cyc();
        chk("resume_first_tick", {value4, tick4}, {8'h01, 1'b1});

        // Load coincident with a step edge
        load_start(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        load = 1'b1;
        load_value = 8'h5A;
        cyc();
        load = 1'b0;
        chk("load_on_step", {value4, tick4, done4, running4}, {8'h59, 1'b0, 1'b0, 1'b0});

        // Mode switch onto the terminal value
        load_start(8'h00, 1'b0);
        for (int i = 0; i < 3; i++) cyc();
        count_down = 1'b1;
        cyc();
        chk("mode_switch_done", {value4, tick4, done4, running4}, {8'h00, 1'b0, 1'b1, 1'b0});
        count_down = 1'b0;

        // DIV_COUNT = 1: step every RUN cycle
        load_start(8'h00, 1'b0);
        chk("div1_running", {value1, running1}, {8'h00, 1'b1});
        for (int k = 1; k <= 5; k++) begin
            cyc();
            chk("div1_step", {value1, tick1}, {bcd(k), 1'b1});
        end

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 999) < 3) do_reset();
            load  = ($urandom_range(0, 99) < 4);
            pause = ($urandom_range(0, 99) < 5);
            start = ($urandom_range(0, 99) < 20);
            if ($urandom_range(0, 99) < 3) count_down = ~count_down;
            load_value = 8'($urandom_range(0, 255));
            cyc();
        end

        // final report
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_interval_timer.md
Name: bcd_interval_timer

Overview:
- Parametrised multi-digit BCD interval timer: a programmable tick divider plus a chain of NUM_DIGITS decimal digits with ripple carry/borrow.
- Supports count-up and count-down modes, start/pause/load control, terminal-count detection and a done pulse.
- Sits between the board clock and the per-digit 7-segment decoders.
- Replaces the fixed 1 Hz single-digit counter.

Parameters:
- NUM_DIGITS, 4, number of BCD digits in the counter (minimum 1).
- DIV_COUNT, 50_000_000, fastclock cycles per count step (minimum 1).
- DIV_W, 26, width of the divider counter; must satisfy 2^DIV_W >= DIV_COUNT.

Ports:
- fastclock  in   1             system clock; all state updates on its rising edge.
- reset      in   1             asynchronous, active-high reset.
- start      in   1             level sampled each cycle; begin or resume counting.
- pause      in   1             level sampled each cycle; freeze counting.
- load       in   1             level sampled each cycle; preset value from load_value.
- count_down in   1             0 = count up, 1 = count down.
- load_value in   4*NUM_DIGITS  preset value; digit i at bits [4i+3:4i].
- value      out  4*NUM_DIGITS  current BCD count; digit 0 (least significant) at [3:0].
- tick       out  1             one-cycle pulse in the cycle value changes by a count step.
- running    out  1             high while in state RUN.
- done       out  1             one-cycle pulse when the terminal count is reached.

Behaviour:
- Reset (asynchronous, active-high): value = 0, divider = 0, state = IDLE, tick = 0, done = 0, running = 0. Reset mid-operation aborts immediately; no done pulse.
- States:
  - IDLE: stopped after reset or load.
  - RUN: counting.
  - PAUSE: frozen, divider residue kept.
  - DONE: terminal count reached.
- Control priority per cycle: load > pause > start.
- Terminal value: all digits 9 in up mode; all digits 0 in down mode. It is evaluated against the current count_down level.
- Transitions:
  - load in any state: value <= load_value with each digit > 9 clamped to 9; divider <= 0; state <= IDLE.
  - pause in RUN: state <= PAUSE; divider holds.
  - pause in other states: ignored.
  - start in IDLE or DONE: if value equals the terminal value, start is ignored (no state change, no done pulse). Otherwise divider <= 0 and state <= RUN.
  - start in PAUSE: state <= RUN; divider resumes from the held residue.
  - start in RUN: no effect.
- Divider runs only in RUN. It counts 0..DIV_COUNT-1. At DIV_COUNT-1 it wraps to 0 and a step occurs on that same edge. With DIV_COUNT = 1, a step occurs every RUN cycle.
- Latency: start sampled on edge N gives running = 1 after edge N. The first step lands on edge N+DIV_COUNT.
- Step, up mode: digit 0 increments. A digit at 9 goes to 0 and carries into the next digit.
- Step, down mode: digit 0 decrements. A digit at 0 goes to 9 and borrows from the next digit.
- The counter never wraps past the terminal value. When a step produces the terminal value, on that same edge:
  - value shows the terminal value;
  - tick = 1 and done = 1 for one cycle;
  - state <= DONE and running <= 0.
- count_down is sampled at each step. A change during RUN takes effect on the next step. If the current value already equals the new mode's terminal value when a step is due, no step occurs; done pulses and state <= DONE.
- tick and done are registered and coincide with the updated value. Both are 0 in every cycle without a step.
- A load coincident with a step edge wins: value = clamped load_value, tick = 0, done = 0.
- value is always legal BCD; no digit ever exceeds 9.
- Width rule: digit arithmetic is 4-bit per digit, with carry/borrow rippling combinationally across NUM_DIGITS in one cycle.

Test Plan (NUM_DIGITS = 2, DIV_COUNT = 4 unless noted):
- Reset and first step: reset, then start for 1 cycle, count_down = 0 -> running = 1; value = 8'h01 with tick after exactly 4 cycles; 8'h02 after 8 cycles. reset asserted mid-count -> value = 8'h00, running = 0 immediately, no done.
- Carry: load 8'h09, start, up mode -> one step gives 8'h10. Load 8'h98 -> steps give 8'h99; done pulses with the second tick... correction: 8'h98 -> 8'h99 in one step, with done = 1 and tick = 1 on that step; state DONE; value holds 8'h99 for 20 further cycles with no tick.
- Down/borrow: load 8'h10, count_down = 1, start -> 8'h09, 8'h08, ... 8'h00; done pulses once on the 8'h00 step. A subsequent start is ignored and running stays 0.
- Pause/resume: start, pause after 2 divider cycles, hold 10 cycles, then start -> first tick arrives 2 cycles after resume (residue kept); value unchanged during the pause.
- Clamp and priority: load_value = 8'hAF with load, pause and start all high together -> value = 8'h99, state IDLE, running = 0. Load coincident with a step -> tick = 0, value = the clamped load value.
- Mode switch and DIV_COUNT = 1: at value 8'h00 running up, set count_down = 1 -> the next step gives done with value 8'h00. Separately, with DIV_COUNT = 1, a step occurs on every RUN cycle.
